// File: rtl/ram_arbiter_if.sv
// Requester-side bus for the RAM arbiter: valid/ready request channel plus
// the one-cycle-later read response.
interface ram_arbiter_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 6
);
   logic              valid;
   logic              ready;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (output valid, we, addr, wdata, input ready, rvalid, rdata);
   modport slave  (input valid, we, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin front end for a single-port synchronous-read RAM.
// Zero-fills the RAM after reset, then grants at most one access per cycle.
module ram_arbiter #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DEPTH  = 32
) (
   input  logic              clk,
   input  logic              rst,
   ram_arbiter_if.slave      a,
   ram_arbiter_if.slave      b,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              init_done
);
   localparam int unsigned      CNT_W   = ADDR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

   typedef enum logic {ST_INIT, ST_SERVE} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  init_cnt_q, init_cnt_d;
   logic              init_done_q, init_done_d;
   logic              last_b_q, last_b_d;
   logic              pend_a_q, pend_a_d;
   logic              pend_b_q, pend_b_d;
   logic              oor_q, oor_d;
   logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
   logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

   logic              serve_c, grant_a_c, grant_b_c;
   logic              g_we_c, g_oor_c;
   logic [ADDR_W-1:0] g_addr_c;
   logic [DATA_W-1:0] g_wdata_c, resp_c;
   logic              a_rvalid_c, b_rvalid_c;

   // Round-robin grant: on contention the requester not granted last wins
   always_comb begin
      serve_c   = (state_q == ST_SERVE) && !rst;
      grant_a_c = serve_c && a.valid && (!b.valid || last_b_q);
      grant_b_c = serve_c && b.valid && (!a.valid || !last_b_q);
      g_we_c    = grant_a_c ? a.we    : b.we;
      g_addr_c  = grant_a_c ? a.addr  : b.addr;
      g_wdata_c = grant_a_c ? a.wdata : b.wdata;
      g_oor_c   = {1'b0, g_addr_c} >= DEPTH_C;
      resp_c    = oor_q ? '0 : ram_dout;
      a_rvalid_c = pend_a_q && !rst;
      b_rvalid_c = pend_b_q && !rst;
   end

   // RAM port drive: zero-fill in INIT, otherwise the granted access
   always_comb begin
      ram_we   = 1'b0;
      ram_addr = '0;
      ram_din  = '0;
      if (state_q == ST_INIT) begin
         ram_we   = 1'b1;
         ram_addr = init_cnt_q[ADDR_W-1:0];
      end else if (grant_a_c || grant_b_c) begin
         ram_addr = g_addr_c;
         if (g_we_c) begin
            ram_we  = !g_oor_c;
            ram_din = g_wdata_c;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      init_done_d = init_done_q;
      last_b_d    = last_b_q;
      pend_a_d    = grant_a_c && !a.we;
      pend_b_d    = grant_b_c && !b.we;
      oor_d       = g_oor_c;
      a_rdata_d   = a_rvalid_c ? resp_c : a_rdata_q;
      b_rdata_d   = b_rvalid_c ? resp_c : b_rdata_q;
      if (state_q == ST_INIT) begin
         init_cnt_d = init_cnt_q + CNT_W'(1);
         if (init_cnt_q == LAST_C) begin
            state_d     = ST_SERVE;
            init_done_d = 1'b1;
         end
      end
      if (grant_a_c || grant_b_c) last_b_d = grant_b_c;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_INIT;
         init_cnt_q  <= '0;
         init_done_q <= 1'b0;
         last_b_q    <= 1'b1;
         pend_a_q    <= 1'b0;
         pend_b_q    <= 1'b0;
         oor_q       <= 1'b0;
         a_rdata_q   <= '0;
         b_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         init_done_q <= init_done_d;
         last_b_q    <= last_b_d;
         pend_a_q    <= pend_a_d;
         pend_b_q    <= pend_b_d;
         oor_q       <= oor_d;
         a_rdata_q   <= a_rdata_d;
         b_rdata_q   <= b_rdata_d;
      end
   end

   // Read data is taken from the RAM in the response cycle itself
   assign a.ready   = grant_a_c;
   assign b.ready   = grant_b_c;
   assign a.rvalid  = a_rvalid_c;
   assign b.rvalid  = b_rvalid_c;
   assign a.rdata   = a_rvalid_c ? resp_c : a_rdata_q;
   assign b.rdata   = b_rvalid_c ? resp_c : b_rdata_q;
   assign init_done = init_done_q;
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Two-port front end for the single-port 8-bit synchronous-read RAM. It zero-fills the RAM after reset, then shares the RAM between requesters A and B. Arbitration is round-robin with a valid/ready handshake, and one access is granted per cycle. Read data is returned to the winning requester one cycle after grant, matching the RAM's registered-address read path.

Parameters:
DATA_W, 8, data width of RAM and requester data ports
ADDR_W, 6, width of address ports (RAM address port width)
DEPTH, 32, number of implemented RAM words; addresses >= DEPTH are out of range

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous active-high reset
a_valid  input  1  requester A access request
a_ready  output  1  A granted this cycle (transfer when a_valid & a_ready)
a_we  input  1  A: 1 = write, 0 = read
a_addr  input  ADDR_W  A address
a_wdata  input  DATA_W  A write data
a_rvalid  output  1  A read data valid
a_rdata  output  DATA_W  A read data
b_valid, b_ready, b_we, b_addr, b_wdata, b_rvalid, b_rdata  same as A, for requester B
ram_we  output  1  to RAM write_enable
ram_addr  output  ADDR_W  to RAM address
ram_din  output  DATA_W  to RAM data_in
ram_dout  input  DATA_W  from RAM data_out (word at address registered on the last non-write edge)
init_done  output  1  high once zero-fill is complete

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state = INIT, init_cnt = 0, last_grant = B (so A wins the first contention).
  - init_done = 0; a_ready = b_ready = 0; a_rvalid = b_rvalid = 0; a_rdata = b_rdata = 0.
- INIT state:
  - Drives ram_we = 1, ram_addr = init_cnt, ram_din = 0; init_cnt increments each cycle.
  - After the write to DEPTH-1 (exactly DEPTH cycles), goes to SERVE and sets init_done = 1 (registered, stays high until rst).
  - No grants in INIT: *_ready = 0 regardless of *_valid.
- SERVE arbitration (combinational, same cycle):
  - Only one valid: that requester is granted.
  - Both valid: grant the requester that is not last_grant.
  - Neither valid: no grant.
  - last_grant updates on the clock edge only when a grant occurs.
  - Requesters hold valid, we, addr and wdata stable until ready. Dropping valid before grant is legal (request withdrawn).
- Granted write:
  - ram_we = 1, ram_addr = addr, ram_din = wdata.
  - Writes to addr >= DEPTH are still granted but drive ram_we = 0 (silently dropped).
- Granted read:
  - ram_we = 0, ram_addr = addr.
  - Next cycle the winner's rvalid = 1 for exactly one cycle; rdata = ram_dout, or 0 if the granted addr >= DEPTH (range flag pipelined with the grant).
  - rdata holds its last value while rvalid = 0.
- No grant: ram_we = 0, ram_addr = 0, ram_din = 0.
- Throughput and ordering:
  - Back-to-back reads are fully pipelined, one per cycle, and responses are in grant order.
  - Read then write in the next cycle: the response still reflects the pre-write data, because the RAM address is held during the write and the data is sampled in the response cycle.
  - Write then read of the same address: the read returns the new data.
- Reset mid-operation: any pending response is discarded (rvalid forced 0), FSM returns to INIT and the full zero-fill repeats.
- Widths: init_cnt is ADDR_W+1 bits so that DEPTH = 2^ADDR_W does not wrap early.

Test Plan:
- Reset then idle: init_done rises exactly 32 cycles after rst falls; ram_we = 1 with ram_addr 0..31 during that window; reads of addr 0, 17 and 31 return 0x00.
- A writes 0x5A to addr 3, then reads addr 3: a_ready high in the grant cycles; a_rvalid = 1 with a_rdata = 0x5A one cycle after the read grant; b_rvalid stays 0.
- A and B both hold reads (A: addr 1 containing 0x11, B: addr 2 containing 0x22) for 4 cycles: grants alternate A, B, A, B; responses alternate 0x11 / 0x22, each one cycle after its grant.
- Requests asserted during INIT: no ready until init_done = 1; the first SERVE cycle grants A if both are valid.
- B writes 0xFF to addr 40, then reads addr 40: both are granted; no RAM write occurs (ram_we = 0); b_rdata = 0x00 with b_rvalid = 1.
- rst asserted in the cycle after a read grant: no rvalid pulse; init_done returns to 0; a full 32-cycle zero-fill repeats.
